// File: rtl/l2_page_arbiter.sv
// l2_page_arbiter: two-client page-fill arbiter streaming pages word-by-word from a single-outstanding-read memory
module l2_page_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int PAGE_BYTES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_start,
    input  logic [ADDR_WIDTH-1:0] c0_page,
    output logic                  c0_launch,
    output logic                  c0_ready,
    input  logic                  c1_start,
    input  logic [ADDR_WIDTH-1:0] c1_page,
    output logic                  c1_launch,
    output logic                  c1_ready,
    output logic                  l2_busy,
    output logic [15:0]           l2_data,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [15:0]           mem_rdata
);
    localparam int PAGE_WORDS  = PAGE_BYTES / 2;
    localparam int OFFSET_BITS = $clog2(PAGE_BYTES);
    localparam int IDX_BITS    = $clog2(PAGE_WORDS);
    localparam int PAGE_BITS   = ADDR_WIDTH - OFFSET_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PAGE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DELIVER} state_t;

    state_t                 state, state_n;
    logic                   sel, sel_n;
    logic [IDX_BITS-1:0]    idx, idx_n;
    logic [PAGE_BITS-1:0]   page, page_n;
    logic                   c0_launch_n, c1_launch_n, c0_ready_n, c1_ready_n, l2_busy_n, mem_rd_n;
    logic [15:0]            l2_data_n;
    logic [ADDR_WIDTH-1:0]  mem_addr_n;

    // State and every output are registered; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sel       <= 1'b0;
            idx       <= '0;
            page      <= '0;
            c0_launch <= 1'b0;
            c1_launch <= 1'b0;
            c0_ready  <= 1'b0;
            c1_ready  <= 1'b0;
            l2_busy   <= 1'b0;
            l2_data   <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            idx       <= idx_n;
            page      <= page_n;
            c0_launch <= c0_launch_n;
            c1_launch <= c1_launch_n;
            c0_ready  <= c0_ready_n;
            c1_ready  <= c1_ready_n;
            l2_busy   <= l2_busy_n;
            l2_data   <= l2_data_n;
            mem_rd    <= mem_rd_n;
            mem_addr  <= mem_addr_n;
        end
    end

    // Grant (port 0 first), issue one word read at a time, strobe each word for a single cycle
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        idx_n       = idx;
        page_n      = page;
        c0_launch_n = c0_launch;
        c1_launch_n = c1_launch;
        c0_ready_n  = c0_ready;
        c1_ready_n  = c1_ready;
        l2_busy_n   = l2_busy;
        l2_data_n   = l2_data;
        mem_rd_n    = mem_rd;
        mem_addr_n  = mem_addr;
        case (state)
            S_IDLE: begin
                if (c0_start || c1_start) begin
                    sel_n       = !c0_start;
                    page_n      = c0_start ? PAGE_BITS'(c0_page) : PAGE_BITS'(c1_page);
                    c0_launch_n = c0_start;
                    c1_launch_n = !c0_start;
                    l2_busy_n   = 1'b1;
                    idx_n       = '0;
                    mem_rd_n    = 1'b1;
                    mem_addr_n  = {page_n, idx_n, 1'b0};
                    state_n     = S_READ;
                end
            end
            S_READ: begin
                if (mem_valid) begin
                    l2_data_n  = mem_rdata;
                    c0_ready_n = !sel;
                    c1_ready_n = sel;
                    mem_rd_n   = 1'b0;
                    state_n    = S_DELIVER;
                end
            end
            S_DELIVER: begin
                c0_ready_n = 1'b0;
                c1_ready_n = 1'b0;
                if (idx == LAST_IDX) begin
                    c0_launch_n = 1'b0;
                    c1_launch_n = 1'b0;
                    l2_busy_n   = 1'b0;
                    state_n     = S_IDLE;
                end else begin
                    idx_n      = idx + 1'b1;
                    mem_rd_n   = 1'b1;
                    mem_addr_n = {page, idx_n, 1'b0};
                    state_n    = S_READ;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
